// File: rtl/keypad_scan_reader_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scan_reader_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned KEY_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } kp_state_e;

  typedef struct packed {
    logic             hit;
    logic [KEY_W-1:0] code;
  } frame_res_t;

endpackage

// File: rtl/keypad_scan_reader_if.sv
// Keypad pins plus the key-event/digit bus toward the display block.
interface keypad_scan_reader_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       digit_clr;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [7:0] digits;

  modport slave (
    input  col_in, digit_clr,
    output row_out, key_code, key_valid, key_held, digits
  );

  modport master (
    output col_in, digit_clr,
    input  row_out, key_code, key_valid, key_held, digits
  );
endinterface

// File: rtl/keypad_scan_reader_frame_capture.sv
// Row scanner: drives one row per clock, samples columns, priority-encodes a full frame.
module keypad_frame_capture
  import keypad_scan_reader_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic       frame_done_o,
  output frame_res_t frame_res_o
);

  logic [1:0] row_q, row_d;
  frame_res_t acc_q, acc_d;
  frame_res_t sample;
  frame_res_t base;

  assign row_o        = ~(4'b0001 << row_q);
  assign frame_done_o = (row_q == 2'd3);

  // Result is combinational on the row-3 edge so the debounce sees it on that same edge.
  always_comb begin
    sample = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!sample.hit && !col_i[c]) begin
        sample.hit  = 1'b1;
        sample.code = {row_q, c[1:0]};
      end
    end
    base        = (row_q == 2'd0) ? frame_res_t'('0) : acc_q;
    acc_d       = base.hit ? base : sample;
    frame_res_o = acc_d;
    row_d       = row_q + 2'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
      acc_q <= '0;
    end else begin
      row_q <= row_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/keypad_scan_reader.sv
// Keypad scan reader: debounces full-scan frames and emits hex key events into a two-digit register.
module keypad_scan_reader
  import keypad_scan_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic                 clk190hz,
  input  logic                 rst,
  keypad_scan_reader_if.slave  kp
);

  localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_FRAMES);

  logic       frame_done;
  frame_res_t frame_res;

  kp_state_e  state_q, state_d;
  frame_res_t prev_q, prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic [7:0] digits_q, digits_d;
  logic       accept;

  keypad_frame_capture u_capture (
    .clk_i        (clk190hz),
    .rst_i        (rst),
    .col_i        (kp.col_in),
    .row_o        (kp.row_out),
    .frame_done_o (frame_done),
    .frame_res_o  (frame_res)
  );

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    held_d   = held_q;
    digits_d = digits_q;
    accept   = 1'b0;

    if (frame_done) begin
      if (frame_res == prev_q) begin
        if (cnt_q < DB_CNT) cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d  = 4'd1;
        prev_d = frame_res;
      end

      // FSM looks at the post-update count so acceptance lands on the frame that reaches it.
      unique case (state_q)
        IDLE: if (cnt_d == DB_CNT && frame_res.hit) begin
          accept  = 1'b1;
          state_d = HELD;
          code_d  = frame_res.code;
          valid_d = 1'b1;
          held_d  = 1'b1;
        end
        HELD: if (cnt_d == DB_CNT && !frame_res.hit) begin
          state_d = IDLE;
          held_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept)
      digits_d = kp.digit_clr ? {4'h0, frame_res.code} : {digits_q[3:0], frame_res.code};
    else if (kp.digit_clr)
      digits_d = '0;
  end

  always_ff @(posedge clk190hz or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
      digits_q <= digits_d;
    end
  end

  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign kp.digits    = digits_q;

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Directed bench for keypad_scan_reader: models a pressed-key matrix and checks key events.
module tb_keypad_scan_reader;

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
    logic [7:0]  exp_digits;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] press = '0;
  logic        clr = 1'b0;
  logic [3:0]  col_drv;
  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt = 0;

  keypad_scan_reader_if kp ();

  keypad_scan_reader #(.DEBOUNCE_FRAMES(4)) dut (
    .clk190hz (clk),
    .rst      (rst),
    .kp       (kp)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.row_out[r] && press[r*4+c]) col_drv[c] = 1'b0;
  end
  assign kp.col_in    = col_drv;
  assign kp.digit_clr = clr;

  always @(negedge clk) if (kp.key_valid === 1'b1) pulse_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row_out"},   32'(kp.row_out),   32'hE);
    chk({tag, "_key_code"},  32'(kp.key_code),  32'h0);
    chk({tag, "_key_valid"}, 32'(kp.key_valid), 32'h0);
    chk({tag, "_key_held"},  32'(kp.key_held),  32'h0);
    chk({tag, "_digits"},    32'(kp.digits),    32'h00);
  endtask

  task automatic do_reset;
    press = '0;
    clr   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("reset");
    step(2);
    rst = 1'b0;
  endtask

  vec_t vecs[$];
  int   base;

  initial begin
    // key bits: bit index = row*4+col
    vecs.push_back('{16'h0010, 5, 1, 4'h4, 1'b1, 8'h94});  // key 4
    vecs.push_back('{16'h0000, 5, 0, 4'h4, 1'b0, 8'h94});
    vecs.push_back('{16'h0020, 1, 0, 4'h4, 1'b0, 8'h94});  // key 5 bounce
    vecs.push_back('{16'h0000, 1, 0, 4'h4, 1'b0, 8'h94});
    vecs.push_back('{16'h0020, 1, 0, 4'h4, 1'b0, 8'h94});
    vecs.push_back('{16'h0000, 1, 0, 4'h4, 1'b0, 8'h94});
    vecs.push_back('{16'h0020, 3, 0, 4'h4, 1'b0, 8'h94});
    vecs.push_back('{16'h0020, 1, 1, 4'h5, 1'b1, 8'h45});
    vecs.push_back('{16'h0000, 5, 0, 4'h5, 1'b0, 8'h45});
    vecs.push_back('{16'h1008, 5, 1, 4'h3, 1'b1, 8'h53});  // keys 3 + C
    vecs.push_back('{16'h1000, 6, 0, 4'h3, 1'b1, 8'h53});  // slide to C only
    vecs.push_back('{16'h0000, 5, 0, 4'h3, 1'b0, 8'h53});
    vecs.push_back('{16'h00E0, 5, 1, 4'h5, 1'b1, 8'h35});  // 5,6,7 same row
    vecs.push_back('{16'h0000, 5, 0, 4'h5, 1'b0, 8'h35});
    vecs.push_back('{16'h8000, 5, 1, 4'hF, 1'b1, 8'h5F});  // key F
    vecs.push_back('{16'h0000, 5, 0, 4'hF, 1'b0, 8'h5F});
    vecs.push_back('{16'h0001, 5, 1, 4'h0, 1'b1, 8'hF0});  // key 0
    vecs.push_back('{16'h0000, 5, 0, 4'h0, 1'b0, 8'hF0});
    vecs.push_back('{16'h0002, 3, 0, 4'h0, 1'b0, 8'hF0});  // too short
    vecs.push_back('{16'h0000, 5, 0, 4'h0, 1'b0, 8'hF0});

    // Idle scan: row sequence and no events
    do_reset();
    base = pulse_cnt;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("idle_row_%0d", k), 32'(kp.row_out), 32'(~(4'b0001 << (k % 4)) & 4'hF));
    end
    step(32);
    chk("idle_pulses", 32'(pulse_cnt - base), 32'd0);
    chk("idle_digits", 32'(kp.digits), 32'h00);

    // Clean press of key 9 from frame 0: accepted on edge 16
    do_reset();
    press = 16'h0200;
    base  = pulse_cnt;
    step(15);
    chk("lat_no_early", 32'(pulse_cnt - base), 32'd0);
    step(1);
    chk("lat_valid_e16", 32'(kp.key_valid), 32'h1);
    chk("lat_code",      32'(kp.key_code),  32'h9);
    chk("lat_digits",    32'(kp.digits),    32'h09);
    chk("lat_held",      32'(kp.key_held),  32'h1);
    press = '0;
    step(1);
    chk("lat_valid_1cyc", 32'(kp.key_valid), 32'h0);
    step(14);
    chk("rel_held_e31", 32'(kp.key_held), 32'h1);
    step(1);
    chk("rel_held_e32", 32'(kp.key_held), 32'h0);
    chk("lat_pulses",   32'(pulse_cnt - base), 32'd1);

    // Frame-aligned vector table
    foreach (vecs[i]) begin
      press = vecs[i].mask;
      base  = pulse_cnt;
      step(vecs[i].frames * 4);
      chk($sformatf("v%0d_pulses", i), 32'(pulse_cnt - base), 32'(vecs[i].exp_pulses));
      chk($sformatf("v%0d_code", i),   32'(kp.key_code),      32'(vecs[i].exp_code));
      chk($sformatf("v%0d_held", i),   32'(kp.key_held),      32'(vecs[i].exp_held));
      chk($sformatf("v%0d_digits", i), 32'(kp.digits),        32'(vecs[i].exp_digits));
    end

    // digit_clr coincident with accepting key A
    press = 16'h0400;
    base  = pulse_cnt;
    step(15);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_acc_valid",  32'(kp.key_valid), 32'h1);
    chk("clr_acc_digits", 32'(kp.digits),    32'h0A);
    chk("clr_acc_code",   32'(kp.key_code),  32'hA);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_only_digits", 32'(kp.digits),   32'h00);
    chk("clr_only_code",   32'(kp.key_code), 32'hA);
    chk("clr_only_held",   32'(kp.key_held), 32'h1);
    chk("clr_pulses",      32'(pulse_cnt - base), 32'd1);

    // Asynchronous reset mid-frame while held
    step(1);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    press = '0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_restart_row1", 32'(kp.row_out), 32'hD);
    base = pulse_cnt;
    step(20);
    chk("rst_quiet_pulses", 32'(pulse_cnt - base), 32'd0);
    chk("rst_quiet_held",   32'(kp.key_held),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scan_reader.md
Name: keypad_scan_reader

Overview:
- Input-side counterpart of the multiplexed 7-segment display path.
- The display block scans digit enables out. This block scans a 4x4 matrix keypad: it drives one row at a time, reads the columns back, debounces, and emits hex key events.
- Accepted keys are shifted into a two-nibble register that feeds the display block's two 4-bit digit inputs directly.
- Runs on the same slow scan clock as the display.

Parameters:
DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required to accept a press or a release (legal range 2..15)

Ports:
clk190hz  input  1  scan clock, rising-edge
rst  input  1  asynchronous, active-high reset
col_in  input  4  keypad columns, active-low (pulled up externally)
row_out  output  4  keypad row drive, active-low one-cold
digit_clr  input  1  synchronous clear of digits
key_code  output  4  last accepted key, row*4+col
key_valid  output  1  one-cycle pulse per accepted press
key_held  output  1  high while an accepted key is still held
digits  output  8  {previous key, latest key}; low nibble is the newest

Behaviour:
Reset values:
- row_out=4'b1110, key_code=0, key_valid=0, key_held=0, digits=8'h00.
- Row index, frame accumulator, debounce counter and stored frame result are all 0.
- FSM starts in IDLE.
- Reset asserted mid-frame discards the partial frame; scanning restarts at row 0.

Scan timing:
- Row index r counts 0,1,2,3,0,... with one clock per row.
- row_out = ~(1<<r).
- On each rising edge, col_in is sampled for the currently driven row.
- A frame is 4 cycles. It completes on the edge that samples row 3.

Frame result:
- The first pressed key in row-major order (lowest row, then lowest column) wins.
- Encoded as {hit, code[3:0]}. No key pressed gives hit=0, code=0.
- Multiple keys pressed: the lowest index wins, with no error flag.

Debounce:
- At each frame end, compare the new result with the stored previous result.
- If equal: stable count increments, saturating at DEBOUNCE_FRAMES.
- If different: stable count = 1 and the stored result is updated.

FSM (evaluated on frame-end edges only):
- IDLE: stable count reaches DEBOUNCE_FRAMES with hit=1 -> HELD. On that edge: key_code<=code, key_valid<=1, key_held<=1, digits<={digits[3:0],code}.
- HELD: stable count reaches DEBOUNCE_FRAMES with hit=0 -> IDLE, key_held<=0.
- HELD: a different key (with or without release bounce) produces no event; a release is mandatory before the next press.

Output rules:
- key_valid is high for exactly one clock cycle. All other cycles it is 0.
- Latency: a clean press present from the start of frame 0 produces key_valid registered on the frame-end edge of frame DEBOUNCE_FRAMES-1 (edge 16 with the default).
- digit_clr alone: digits<=8'h00 on the next edge.
- digit_clr coincident with an accepted key: digits<={4'h0,code}.
- key_code holds its value until the next accepted key. digit_clr does not affect key_code.
- Width rule: code = {r[1:0], c[1:0]}, with no arithmetic overflow possible.

Decomposition:
- Shared package:
  - ROWS=4, COLS=4
  - KEY_W=4
  - FSM state enum {IDLE, HELD}
  - frame-result struct {hit, code}
- Sub-module keypad_frame_capture: row counter, row_out drive, column sampling, priority encode. Outputs frame_done pulse plus frame result.
- Debounce counter, FSM and digit register stay in the top of keypad_scan_reader.

Test Plan:
1. Reset, no key pressed (col_in=4'hF) for 40 cycles -> row_out cycles 1110,1101,1011,0111; key_valid never rises; digits=00.
2. Press row 2 col 1 (col_in[1]=0 only while row_out=1011), held clean from frame start -> single key_valid pulse at edge 16; key_code=9; digits=09; key_held=1. Release clean -> key_held falls 4 frames later.
3. Press key 9 then key 4, each with a clean release -> digits=94, exactly two key_valid pulses.
4. Bounce on key 5 (toggling every frame for 3 frames, then stable) -> exactly one key_valid pulse, 4 frames after stabilisation begins; no event during the bounce.
5. Hold key 3 while key C is also pressed -> key_code=3 (lowest index wins). Switch directly from key 3 to key C without release -> no new pulse; key_held stays 1.
6. Assert rst mid-frame while in HELD -> all outputs return to reset values immediately, asynchronously. Assert digit_clr on the same edge as an accepted key A -> digits=0A.
